// File: rtl/dm_responder_if.sv
// ---------------------------------------------------------------------------
// dm_responder_if
// Request/response bundle between the M stage (master) and the data-memory
// responder (slave).
//   req_valid/req_ready : request handshake, accept when both are high
//   req_we/be/addr/wdata: request payload, sampled only at the accept edge
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata/rsp_err   : response payload, qualified by rsp_valid
//   busy                : stall request towards the pipeline
// ---------------------------------------------------------------------------
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
// Memory-side responder for the M-stage data memory. Accepts one load/store at
// a time, commits stores with byte enables on the accept edge, and returns a
// one-cycle response pulse LATENCY cycles after the accept edge.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low (0 = in reset)
//   bus   : dm_responder_if.slave (request/response handshake and busy)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words in the array
//   LATENCY     : accept edge to rsp_valid cycle, 1..15
//   ADDR_BASE   : byte address of word 0
// ---------------------------------------------------------------------------
module dm_responder #(
    parameter int          DEPTH_WORDS = 3072,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    dm_responder_if.slave  bus
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [31:0]     off;
    logic [29:0]     idx;
    logic [AW-1:0]   req_idx;
    logic            req_err;
    logic            accept;
    logic            enter_resp;

    logic            hold_we, hold_err;
    logic [AW-1:0]   hold_idx;
    logic            rd_we, rd_err;
    logic [AW-1:0]   rd_idx;

    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    // Address decode of the live request; only meaningful at the accept edge.
    always_comb begin
        off     = bus.req_addr - ADDR_BASE;
        idx     = off[31:2];
        req_idx = idx[AW-1:0];
        req_err = (off[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH_WORDS));
    end

    assign accept = (state == ST_IDLE) && bus.req_valid;

    // RESP always returns to IDLE, so any transition into RESP is an entry.
    assign enter_resp = (state_nxt == ST_RESP);

    // With LATENCY==1 the edge entering RESP is the accept edge itself, so the
    // read must use the live request rather than the hold registers.
    always_comb begin
        if (state == ST_IDLE) begin
            rd_we  = bus.req_we;
            rd_err = req_err;
            rd_idx = req_idx;
        end else begin
            rd_we  = hold_we;
            rd_err = hold_err;
            rd_idx = hold_idx;
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.req_valid) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 4'd0)   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = (state == ST_IDLE);
        bus.rsp_valid = (state == ST_RESP);
        bus.busy      = ((state == ST_IDLE) && bus.req_valid) || (state == ST_WAIT);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

    // Wait counter and request hold registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            hold_we  <= 1'b0;
            hold_err <= 1'b0;
            hold_idx <= '0;
        end else if (accept) begin
            cnt      <= CNT_INIT;
            hold_we  <= bus.req_we;
            hold_err <= req_err;
            hold_idx <= req_idx;
        end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response payload: updated only on entry to RESP, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q   <= rd_err;
            rsp_rdata_q <= (rd_we || rd_err) ? 32'd0 : mem[rd_idx];
        end
    end

    // Store commit on the accept edge. Writes are blocked while reset is
    // asserted so a request presented during reset cannot sneak in.
    // NOTE: the array has no reset; clearing thousands of words is neither
    // needed nor implementable as plain RAM.
    always_ff @(posedge clk) begin
        if (reset && accept && bus.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_be[i]) mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// ---------------------------------------------------------------------------
// tb_dm_responder
// Self-checking bench for dm_responder. Instance A uses LATENCY=2, instance B
// uses LATENCY=1. A word-array reference model predicts load data and errors.
// ---------------------------------------------------------------------------
module tb_dm_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_responder_if a_if ();
    dm_responder_if b_if ();

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2), .ADDR_BASE(32'h0)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(1), .ADDR_BASE(32'h0)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [3072];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] addr);
        return ((addr % 4) != 0) || ((addr / 4) >= 3072);
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        if (!addr_err(addr)) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[addr / 4][8*i +: 8] = data[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr);
        return addr_err(addr) ? 32'd0 : ref_mem[addr / 4];
    endfunction

    // One complete transaction on instance A, starting just after a rising edge
    // with the responder idle, and ending just after a rising edge in IDLE.
    task automatic txn_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic rerr);
        int          n;
        bit          got;
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_err = addr_err(addr);
        a_if.req_valid = 1'b1;
        a_if.req_we    = we;
        a_if.req_be    = be;
        a_if.req_addr  = addr;
        a_if.req_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_if.req_ready) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("accept_timeout", 32'(got), 32'd1);
        check("busy_accept", 32'(a_if.busy), 32'd1);
        @(posedge clk); #1;
        if (we) begin
            model_store(addr, be, wdata);
            exp_rd = 32'd0;
        end else begin
            exp_rd = model_load(addr);
        end
        // Payload changes after the accept edge must have no effect.
        a_if.req_valid = 1'b0;
        a_if.req_we    = 1'($urandom);
        a_if.req_be    = 4'($urandom);
        a_if.req_addr  = $urandom;
        a_if.req_wdata = $urandom;
        n   = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_if.rsp_valid) begin got = 1'b1; break; end
            check("busy_wait", 32'(a_if.busy), 32'd1);
            check("ready_wait", 32'(a_if.req_ready), 32'd0);
            n++;
            @(posedge clk); #1;
        end
        check("rsp_timeout", 32'(got), 32'd1);
        check("latency", 32'(n), 32'd2);
        check("busy_resp", 32'(a_if.busy), 32'd0);
        check("rsp_err", 32'(a_if.rsp_err), 32'(exp_err));
        check("rsp_rdata", a_if.rsp_rdata, exp_rd);
        rdata = a_if.rsp_rdata;
        rerr  = a_if.rsp_err;
        @(posedge clk); #1;
        @(negedge clk);
        check("rsp_single_pulse", 32'(a_if.rsp_valid), 32'd0);
        check("ready_after", 32'(a_if.req_ready), 32'd1);
        check("rdata_hold", a_if.rsp_rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] prior;
        logic [31:0] addr;
        int          r;
        bit          e_ready [7] = '{1, 0, 0, 1, 0, 0, 1};
        bit          e_busy  [7] = '{1, 1, 0, 1, 1, 0, 0};
        bit          e_valid [7] = '{0, 0, 1, 0, 0, 1, 0};

        reset = 1'b0;
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_be = 4'h0;
        a_if.req_addr  = 32'h0; a_if.req_wdata = 32'h0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_be = 4'h0;
        b_if.req_addr  = 32'h0; b_if.req_wdata = 32'h0;

        // Reset state
        #2;
        check("reset_ready", 32'(a_if.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("reset_rdata", a_if.rsp_rdata, 32'd0);
        check("reset_err", 32'(a_if.rsp_err), 32'd0);
        check("reset_busy", 32'(a_if.busy), 32'd0);
        check("reset_b_rsp_valid", 32'(b_if.rsp_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Preload a pool of 16 words so every later load has defined data.
        for (int w = 0; w < 16; w++) txn_a(1'b1, 4'hF, 32'(w * 4), $urandom, rd, er);

        // Store then load
        txn_a(1'b1, 4'hF, 32'h10, 32'h1234_5678, rd, er);
        check("t1_store_err", 32'(er), 32'd0);
        txn_a(1'b0, 4'h0, 32'h10, 32'h0, rd, er);
        check("t1_load", rd, 32'h1234_5678);

        // Byte enables
        txn_a(1'b1, 4'b0011, 32'h10, 32'hAAAA_BBBB, rd, er);
        txn_a(1'b0, 4'h0, 32'h10, 32'h0, rd, er);
        check("t2_be_load", rd, 32'h1234_BBBB);
        txn_a(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, er);
        check("t2_be0_err", 32'(er), 32'd0);
        txn_a(1'b0, 4'h0, 32'h10, 32'h0, rd, er);
        check("t2_be0_load", rd, 32'h1234_BBBB);

        // Errors
        txn_a(1'b0, 4'h0, 32'h13, 32'h0, rd, er);
        check("t3_misaligned_err", 32'(er), 32'd1);
        check("t3_misaligned_rdata", rd, 32'd0);
        prior = ref_mem[0];
        txn_a(1'b1, 4'hF, 32'h3000, 32'hDEAD_BEEF, rd, er);
        check("t3_range_err", 32'(er), 32'd1);
        txn_a(1'b0, 4'h0, 32'h0, 32'h0, rd, er);
        check("t3_word0_unchanged", rd, prior);

        // Randomised traffic against the model
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 15)) * 4;
            if (r == 8)      addr = addr + 32'($urandom_range(1, 3));
            else if (r == 9) addr = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
            txn_a(1'($urandom), 4'($urandom), addr, $urandom, rd, er);
        end

        // Hold/busy with req_valid held high across two loads
        a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_be = 4'h0;
        a_if.req_addr  = 32'h10; a_if.req_wdata = 32'h0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) a_if.req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t4_ready_c%0d", c), 32'(a_if.req_ready), 32'(e_ready[c]));
            check($sformatf("t4_busy_c%0d", c), 32'(a_if.busy), 32'(e_busy[c]));
            check($sformatf("t4_valid_c%0d", c), 32'(a_if.rsp_valid), 32'(e_valid[c]));
            if (e_valid[c]) check($sformatf("t4_rdata_c%0d", c), a_if.rsp_rdata, model_load(32'h10));
            @(posedge clk); #1;
        end

        // Reset during WAIT of a store
        a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_be = 4'hF;
        a_if.req_addr  = 32'h20; a_if.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t5_ready_pre", 32'(a_if.req_ready), 32'd1);
        @(posedge clk); #1;
        model_store(32'h20, 4'hF, 32'hCAFE_F00D);
        a_if.req_valid = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t5_in_reset_valid", 32'(a_if.rsp_valid), 32'd0);
            check("t5_in_reset_ready", 32'(a_if.req_ready), 32'd1);
            check("t5_in_reset_rdata", a_if.rsp_rdata, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_after_valid", 32'(a_if.rsp_valid), 32'd0);
            check("t5_after_ready", 32'(a_if.req_ready), 32'd1);
            @(posedge clk); #1;
        end
        txn_a(1'b0, 4'h0, 32'h20, 32'h0, rd, er);
        check("t5_store_kept", rd, 32'hCAFE_F00D);

        // LATENCY=1 instance: store, then loads with req_valid held high
        b_if.req_valid = 1'b1; b_if.req_we = 1'b1; b_if.req_be = 4'hF;
        b_if.req_addr  = 32'h8; b_if.req_wdata = 32'h5A5A_A5A5;
        @(negedge clk);
        check("t6_store_ready", 32'(b_if.req_ready), 32'd1);
        check("t6_store_busy", 32'(b_if.busy), 32'd1);
        @(posedge clk); #1;
        b_if.req_valid = 1'b0;
        @(negedge clk);
        check("t6_store_rsp", 32'(b_if.rsp_valid), 32'd1);
        check("t6_store_err", 32'(b_if.rsp_err), 32'd0);
        check("t6_store_rdata", b_if.rsp_rdata, 32'd0);
        check("t6_store_busy_resp", 32'(b_if.busy), 32'd0);
        @(posedge clk); #1;
        b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 32'h8;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) b_if.req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t6_ready_c%0d", c), 32'(b_if.req_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t6_valid_c%0d", c), 32'(b_if.rsp_valid), (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) check($sformatf("t6_rdata_c%0d", c), b_if.rsp_rdata, 32'h5A5A_A5A5);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
